// File: rtl/minn_pkg.sv
// Shared types and width helpers for the Minn preamble sync controller.
package minn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_HOLDOFF = 2'd3
  } sync_state_e;

  // P = corr_recent + corr_previous needs one growth bit.
  function automatic int p_width(input int corr_w);
    return corr_w + 1;
  endfunction

  // R = energy_recent + energy_previous needs one growth bit.
  function automatic int r_width(input int energy_w);
    return energy_w + 1;
  endfunction

  // Signed compare width holding both P<<<frac and threshold*R exactly,
  // plus a guard bit so neither side can wrap into the sign.
  function automatic int prod_width(input int pw, input int rw, input int tw, input int tf);
    int a, b;
    a = pw + tf;
    b = rw + tw + 1;
    return ((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/minn_metric_gate.sv
// Two-stage P/R sum and divider-free ratio threshold. Also owns the
// free-running sample index so the index travels with its metric.
module minn_metric_gate
  import minn_pkg::*;
#(
  parameter int CORR_WIDTH   = 35,
  parameter int ENERGY_WIDTH = 35,
  parameter int THR_WIDTH    = 16,
  parameter int THR_FRAC     = 15,
  parameter int IDX_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           taps_valid,
  input  logic [THR_WIDTH-1:0]           threshold,
  input  logic signed [CORR_WIDTH-1:0]   corr_recent,
  input  logic signed [CORR_WIDTH-1:0]   corr_previous,
  input  logic signed [ENERGY_WIDTH-1:0] energy_recent,
  input  logic signed [ENERGY_WIDTH-1:0] energy_previous,
  output logic                           metric_valid,
  output logic                           gate,
  output logic signed [CORR_WIDTH:0]     metric_p,
  output logic [IDX_WIDTH-1:0]           metric_idx
);

  localparam int PW = p_width(CORR_WIDTH);
  localparam int RW = r_width(ENERGY_WIDTH);
  localparam int MW = prod_width(PW, RW, THR_WIDTH, THR_FRAC);

  logic [IDX_WIDTH-1:0] sample_idx_q, sample_idx_d;
  logic                 s1_vld_q, s1_vld_d;
  logic signed [PW-1:0] s1_p_q, s1_p_d;
  logic signed [RW-1:0] s1_r_q, s1_r_d;
  logic [IDX_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                 mv_q, mv_d;
  logic                 gate_q, gate_d;
  logic signed [PW-1:0] p2_q, p2_d;
  logic [IDX_WIDTH-1:0] idx2_q, idx2_d;

  logic signed [MW-1:0] p_ext, r_ext, t_ext, lhs, rhs;
  logic                 pass;

  // Ratio test P/R >= thr rewritten as P*2^frac >= thr*R at full precision.
  // R = 0 with P > 0 passes naturally since the right side is 0.
  always_comb begin
    p_ext = {{(MW-PW){s1_p_q[PW-1]}}, s1_p_q};
    r_ext = {{(MW-RW){s1_r_q[RW-1]}}, s1_r_q};
    t_ext = {{(MW-THR_WIDTH){1'b0}}, threshold};
    lhs   = p_ext <<< THR_FRAC;
    rhs   = t_ext * r_ext;
    pass  = !s1_p_q[PW-1] && (s1_p_q != '0) && (lhs >= rhs);
  end

  // Stage 1 captures sums and index; stage 2 captures the gate decision.
  always_comb begin
    sample_idx_d = sample_idx_q;
    s1_vld_d     = taps_valid;
    s1_p_d       = s1_p_q;
    s1_r_d       = s1_r_q;
    s1_idx_d     = s1_idx_q;
    mv_d         = s1_vld_q;
    gate_d       = 1'b0;
    p2_d         = p2_q;
    idx2_d       = idx2_q;
    if (taps_valid) begin
      sample_idx_d = sample_idx_q + IDX_WIDTH'(1);
      s1_p_d       = {corr_recent[CORR_WIDTH-1], corr_recent}
                   + {corr_previous[CORR_WIDTH-1], corr_previous};
      s1_r_d       = {energy_recent[ENERGY_WIDTH-1], energy_recent}
                   + {energy_previous[ENERGY_WIDTH-1], energy_previous};
      s1_idx_d     = sample_idx_q;
    end
    if (s1_vld_q) begin
      gate_d = pass;
      p2_d   = s1_p_q;
      idx2_d = s1_idx_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_idx_q <= '0;
      s1_vld_q     <= 1'b0;
      s1_p_q       <= '0;
      s1_r_q       <= '0;
      s1_idx_q     <= '0;
      mv_q         <= 1'b0;
      gate_q       <= 1'b0;
      p2_q         <= '0;
      idx2_q       <= '0;
    end else begin
      sample_idx_q <= sample_idx_d;
      s1_vld_q     <= s1_vld_d;
      s1_p_q       <= s1_p_d;
      s1_r_q       <= s1_r_d;
      s1_idx_q     <= s1_idx_d;
      mv_q         <= mv_d;
      gate_q       <= gate_d;
      p2_q         <= p2_d;
      idx2_q       <= idx2_d;
    end
  end

  assign metric_valid = mv_q;
  assign gate         = gate_q;
  assign metric_p     = p2_q;
  assign metric_idx   = idx2_q;

endmodule

// File: rtl/minn_sync_controller.sv
// Minn preamble detector: peak search over a fixed window of gated metric
// events, one detect pulse per window, then a holdoff period.
module minn_sync_controller
  import minn_pkg::*;
#(
  parameter int CORR_WIDTH   = 35,
  parameter int ENERGY_WIDTH = 35,
  parameter int THR_WIDTH    = 16,
  parameter int THR_FRAC     = 15,
  parameter int SEARCH_LEN   = 64,
  parameter int HOLDOFF_LEN  = 1024,
  parameter int IDX_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [THR_WIDTH-1:0]           threshold,
  input  logic                           taps_valid,
  input  logic signed [CORR_WIDTH-1:0]   corr_recent,
  input  logic signed [CORR_WIDTH-1:0]   corr_previous,
  input  logic signed [ENERGY_WIDTH-1:0] energy_recent,
  input  logic signed [ENERGY_WIDTH-1:0] energy_previous,
  output logic                           detect_valid,
  output logic [IDX_WIDTH-1:0]           detect_index,
  output logic signed [CORR_WIDTH:0]     detect_peak,
  output logic                           busy
);

  localparam int PW  = p_width(CORR_WIDTH);
  localparam int SCW = $clog2(SEARCH_LEN + 1);
  localparam int HCW = $clog2(HOLDOFF_LEN + 1);

  logic                 mv, gate;
  logic signed [PW-1:0] m_p;
  logic [IDX_WIDTH-1:0] m_idx;

  minn_metric_gate #(
    .CORR_WIDTH  (CORR_WIDTH),
    .ENERGY_WIDTH(ENERGY_WIDTH),
    .THR_WIDTH   (THR_WIDTH),
    .THR_FRAC    (THR_FRAC),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_gate (
    .clk            (clk),
    .rst            (rst),
    .taps_valid     (taps_valid),
    .threshold      (threshold),
    .corr_recent    (corr_recent),
    .corr_previous  (corr_previous),
    .energy_recent  (energy_recent),
    .energy_previous(energy_previous),
    .metric_valid   (mv),
    .gate           (gate),
    .metric_p       (m_p),
    .metric_idx     (m_idx)
  );

  sync_state_e          state_q, state_d;
  logic [SCW-1:0]       search_cnt_q, search_cnt_d;
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic signed [PW-1:0] best_p_q, best_p_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic                 det_vld_q, det_vld_d;
  logic [IDX_WIDTH-1:0] det_idx_q, det_idx_d;
  logic signed [PW-1:0] det_peak_q, det_peak_d;

  // Window event scratch: entry and in-window events share the close-out path
  // so SEARCH_LEN = 1 completes on the entry event itself.
  logic                 win_evt;
  logic [SCW-1:0]       cnt_c;
  logic signed [PW-1:0] bp_c;
  logic [IDX_WIDTH-1:0] bi_c;
  logic [HCW-1:0]       hold_n;

  // Next-state, counters and detect outputs; enable low overrides everything.
  always_comb begin
    state_d      = state_q;
    search_cnt_d = search_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    best_p_d     = best_p_q;
    best_idx_d   = best_idx_q;
    det_vld_d    = 1'b0;
    det_idx_d    = det_idx_q;
    det_peak_d   = det_peak_q;
    win_evt      = 1'b0;
    cnt_c        = search_cnt_q + SCW'(1);
    bp_c         = best_p_q;
    bi_c         = best_idx_q;
    hold_n       = hold_cnt_q + HCW'(1);

    if (!enable) begin
      state_d      = ST_IDLE;
      search_cnt_d = '0;
      hold_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (mv && gate) begin
            win_evt = 1'b1;
            cnt_c   = SCW'(1);
            bp_c    = m_p;
            bi_c    = m_idx;
          end
        end
        ST_SEARCH: begin
          if (mv) begin
            win_evt = 1'b1;
            // Strictly greater keeps the earliest of equal peaks.
            if (gate && (m_p > best_p_q)) begin
              bp_c = m_p;
              bi_c = m_idx;
            end
          end
        end
        ST_HOLDOFF: begin
          if (mv) begin
            if (hold_n == HCW'(HOLDOFF_LEN)) begin
              state_d    = ST_ARMED;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_n;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (win_evt) begin
        best_p_d   = bp_c;
        best_idx_d = bi_c;
        if (cnt_c == SCW'(SEARCH_LEN)) begin
          state_d      = ST_HOLDOFF;
          search_cnt_d = '0;
          hold_cnt_d   = '0;
          det_vld_d    = 1'b1;
          det_idx_d    = bi_c;
          det_peak_d   = bp_c;
        end else begin
          state_d      = ST_SEARCH;
          search_cnt_d = cnt_c;
        end
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      search_cnt_q <= '0;
      hold_cnt_q   <= '0;
      best_p_q     <= '0;
      best_idx_q   <= '0;
      det_vld_q    <= 1'b0;
      det_idx_q    <= '0;
      det_peak_q   <= '0;
    end else begin
      state_q      <= state_d;
      search_cnt_q <= search_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      best_p_q     <= best_p_d;
      best_idx_q   <= best_idx_d;
      det_vld_q    <= det_vld_d;
      det_idx_q    <= det_idx_d;
      det_peak_q   <= det_peak_d;
    end
  end

  assign detect_valid = det_vld_q;
  assign detect_index = det_idx_q;
  assign detect_peak  = det_peak_q;
  assign busy         = (state_q == ST_SEARCH) || (state_q == ST_HOLDOFF);

endmodule
